// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_pkg: shared constants, scoreboard entry type and match helper for the
// pipeline hazard controller.
package pipe_pkg;

    localparam int SB_ADDR_W = 4;

    localparam logic [1:0] PCSEL_SEQ   = 2'b00;
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEM     = 2'b01;
    localparam logic [1:0] FWD_WB      = 2'b10;

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] dAddr;
        logic                 isLoad;
    } sb_entry_t;

    function automatic logic sb_match(input sb_entry_t e, input logic use_src,
                                      input logic [SB_ADDR_W-1:0] addr);
        return use_src && e.valid && (e.dAddr == addr);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decoder/EX-side signal bundle of the hazard controller; the controller
// uses the slave modport, the decoder/datapath side the master modport.
interface pipe_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_s1RegAddr;
    logic [REG_ADDR_W-1:0] id_s2RegAddr;
    logic                  id_useS1;
    logic                  id_useS2;
    logic [REG_ADDR_W-1:0] id_dRegAddr;
    logic                  id_regFileWrtEn;
    logic                  id_isLoad;
    logic [1:0]            ex_pcSel;
    logic                  stall;
    logic                  flush_if;
    logic                  flush_id;
    logic                  ex_valid;
    logic [1:0]            fwd_s1Sel;
    logic [1:0]            fwd_s2Sel;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output id_valid, id_s1RegAddr, id_s2RegAddr, id_useS1, id_useS2,
               id_dRegAddr, id_regFileWrtEn, id_isLoad, ex_pcSel,
        input  stall, flush_if, flush_id, ex_valid, fwd_s1Sel, fwd_s2Sel,
               stall_count
    );

    modport slave (
        input  id_valid, id_s1RegAddr, id_s2RegAddr, id_useS1, id_useS2,
               id_dRegAddr, id_regFileWrtEn, id_isLoad, ex_pcSel,
        output stall, flush_if, flush_id, ex_valid, fwd_s1Sel, fwd_s2Sel,
               stall_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// pipe_scoreboard: EX/MEM/WB shift register of in-flight register writes and
// per-source match vectors (bit 0 = EX, 1 = MEM, 2 = WB).
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [REG_ADDR_W-1:0] i_dAddr,
    input  logic                  i_isLoad,
    input  logic                  i_useS1,
    input  logic [REG_ADDR_W-1:0] i_s1Addr,
    input  logic                  i_useS2,
    input  logic [REG_ADDR_W-1:0] i_s2Addr,
    output logic [2:0]            o_s1_match,
    output logic [2:0]            o_s2_match,
    output logic                  o_ex_isLoad
);

    sb_entry_t r_ex, r_mem, r_wb;

    // Only the valid bits need reset; address/isLoad are qualified by valid.
    always_ff @(posedge clk) begin
        r_ex  <= '{valid: i_load, dAddr: SB_ADDR_W'(i_dAddr), isLoad: i_isLoad};
        r_mem <= r_ex;
        r_wb  <= r_mem;
        if (reset) begin
            r_ex.valid  <= 1'b0;
            r_mem.valid <= 1'b0;
            r_wb.valid  <= 1'b0;
        end
    end

    assign o_s1_match = {sb_match(r_wb,  i_useS1, SB_ADDR_W'(i_s1Addr)),
                         sb_match(r_mem, i_useS1, SB_ADDR_W'(i_s1Addr)),
                         sb_match(r_ex,  i_useS1, SB_ADDR_W'(i_s1Addr))};
    assign o_s2_match = {sb_match(r_wb,  i_useS2, SB_ADDR_W'(i_s2Addr)),
                         sb_match(r_mem, i_useS2, SB_ADDR_W'(i_s2Addr)),
                         sb_match(r_ex,  i_useS2, SB_ADDR_W'(i_s2Addr))};
    assign o_ex_isLoad = r_ex.isLoad;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forwarding control for the 5-stage pipeline.
// Optional feature macro: PIPE_HAZARD_FORWARD_EN (operand forwarding).
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input logic              clk,
    input logic              reset,
    pipe_hazard_ctrl_if.slave bus
);

    logic [2:0]       w_s1_match;
    logic [2:0]       w_s2_match;
    logic             w_ex_isLoad;
    logic             w_redirect;
    logic             w_hazard;
    logic             w_stall;
    logic             w_advance;
    logic             w_unused;
    logic             r_ex_valid;
    logic [CNT_W-1:0] r_stall_count;

    pipe_scoreboard #(.REG_ADDR_W(REG_ADDR_W)) u_sb (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_advance && bus.id_regFileWrtEn),
        .i_dAddr     (bus.id_dRegAddr),
        .i_isLoad    (bus.id_isLoad),
        .i_useS1     (bus.id_useS1),
        .i_s1Addr    (bus.id_s1RegAddr),
        .i_useS2     (bus.id_useS2),
        .i_s2Addr    (bus.id_s2RegAddr),
        .o_s1_match  (w_s1_match),
        .o_s2_match  (w_s2_match),
        .o_ex_isLoad (w_ex_isLoad)
    );

    assign w_redirect = r_ex_valid && (bus.ex_pcSel != PCSEL_SEQ);

`ifdef PIPE_HAZARD_FORWARD_EN
    logic [1:0] r_fwd_s1, r_fwd_s2;

    // Youngest producer wins; a load in EX never reaches here because it stalls.
    function automatic logic [1:0] pick_fwd(input logic [1:0] m, input logic ex_is_load);
        if (m[0] && !ex_is_load) return FWD_MEM;
        if (m[1])                return FWD_WB;
        return FWD_REGFILE;
    endfunction

    assign w_hazard = bus.id_valid && w_ex_isLoad && (w_s1_match[0] || w_s2_match[0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fwd_s1 <= FWD_REGFILE;
            r_fwd_s2 <= FWD_REGFILE;
        end else if (w_advance) begin
            r_fwd_s1 <= pick_fwd(w_s1_match[1:0], w_ex_isLoad);
            r_fwd_s2 <= pick_fwd(w_s2_match[1:0], w_ex_isLoad);
        end else begin
            r_fwd_s1 <= FWD_REGFILE;
            r_fwd_s2 <= FWD_REGFILE;
        end
    end

    assign bus.fwd_s1Sel = r_fwd_s1;
    assign bus.fwd_s2Sel = r_fwd_s2;
    assign w_unused      = ^{w_s1_match[2], w_s2_match[2]};
`else
    // Without forwarding, wait until the producer has left MEM (WB is write-before-read).
    assign w_hazard = bus.id_valid && ((|w_s1_match[1:0]) || (|w_s2_match[1:0]));

    assign bus.fwd_s1Sel = FWD_REGFILE;
    assign bus.fwd_s2Sel = FWD_REGFILE;
    assign w_unused      = ^{w_s1_match[2], w_s2_match[2], w_ex_isLoad};
`endif

    assign w_stall   = w_hazard && !w_redirect;
    assign w_advance = bus.id_valid && !w_stall && !w_redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid    <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_ex_valid <= w_advance;
            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    assign bus.stall       = w_stall;
    assign bus.flush_if    = w_redirect;
    assign bus.flush_id    = w_redirect;
    assign bus.ex_valid    = r_ex_valid;
    assign bus.stall_count = r_stall_count;

endmodule
